// File: rtl/game_pkg.sv
// Shared constants for the game counters and timers.
// Direction encodings are applied to the up_down input of mod_counter.
package game_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_tick_gen.sv
// Prescaler: pulses tick on every PRESCALE-th enabled clock; reusable by other timers.
// With PRESCALE=1 it has no register and tick simply follows enable.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, CLOCK_50, reset, sync_clr};
      assign tick      = enable;
    end else begin : g_cnt
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] presc_q;
      logic [PW-1:0] presc_d;

      always_comb begin
        presc_d = presc_q;
        if (sync_clr) begin
          presc_d = '0;
        end else if (enable) begin
          presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
      end

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_d;
        end
      end

      assign tick = enable && (presc_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with prescaler, load/clear, wrap-or-saturate
// and a registered terminal-count pulse.
module mod_counter
  import game_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 15,
  parameter int PRESCALE  = 1,
  parameter int SATURATE  = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] outvalue,
  output logic             tc
);

  generate
    if (longint'(MAX_VALUE) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
      $error("mod_counter: MAX_VALUE %0d does not fit in WIDTH %0d", MAX_VALUE, WIDTH);
    end
    if (PRESCALE < 1) begin : g_bad_presc
      $error("mod_counter: PRESCALE %0d must be >= 1", PRESCALE);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;

  // clear and load restart the prescale period as well as the count.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .sync_clr (clear | load),
    .tick     (step)
  );

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (load_value > MAX_V) ? MAX_V : load_value;
    end else if (step) begin
      if (up_down == CNT_UP) begin
        if (cnt_q == MAX_V) begin
          tc_d  = 1'b1;
          cnt_d = SAT ? MAX_V : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          cnt_d = SAT ? '0 : MAX_V;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign outvalue = cnt_q;
  assign tc       = tc_q;

endmodule
